// File: rtl/pico_io_ports.sv
// KCPSM3 I/O port block: output registers, synchronized inputs,
// optional edge flags + interrupt (enabled by macro PIO_EDGE_IRQ_EN).
module pico_io_ports #(
    parameter int         NUM_OUT   = 2,
    parameter int         NUM_IN    = 2,
    parameter logic [7:0] OUT_RESET = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    input  logic [7:0]            out_port,
    output logic [7:0]            in_port,
    output logic                  interrupt,
    input  logic                  interrupt_ack,
    input  logic [8*NUM_IN-1:0]   in_pins,
    output logic [8*NUM_OUT-1:0]  out_pins
);

    localparam int IW = 8 * NUM_IN;

    logic [7:0]    r_out [NUM_OUT];
    logic [IW-1:0] r_sync1;
    logic [IW-1:0] r_sync2;
    logic [7:0]    r_in_port;
    logic [7:0]    w_rd;
    logic          w_unused;

    // read_strobe carries no side effects; ack is unused without the IRQ logic
    assign w_unused = read_strobe ^ interrupt_ack;

    // Output registers: written when the strobe hits an implemented index
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) r_out[i] <= OUT_RESET;
        end else if (write_strobe && port_id[7:4] == 4'h0) begin
            for (int i = 0; i < NUM_OUT; i++)
                if (port_id[3:0] == 4'(i)) r_out[i] <= out_port;
        end
    end

    genvar g;
    for (g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_pins[8*g +: 8] = r_out[g];
    end

    // Two-flop synchronizer for the asynchronous input pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_pins;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_EDGE_IRQ_EN
    logic [IW-1:0]     r_prev;
    logic [IW-1:0]     r_flag;
    logic [NUM_IN-1:0] r_en;
    logic              r_irq;
    logic [IW-1:0]     w_rise;
    logic [IW-1:0]     w_clr;
    logic [IW-1:0]     w_en_bits;
    logic [IW-1:0]     w_flag_next;
    logic              w_irq_set;

    // Per-bit W1C clear mask and per-port enable expanded to flag bits
    always_comb begin
        w_clr     = '0;
        w_en_bits = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (write_strobe && port_id == 8'h20 + 8'(i))
                w_clr[8*i +: 8] = out_port;
            w_en_bits[8*i +: 8] = {8{r_en[i]}};
        end
    end

    // Set wins over clear; only fresh 0->1 flags on enabled ports interrupt
    assign w_rise      = r_sync2 & ~r_prev;
    assign w_flag_next = (r_flag & ~w_clr) | w_rise;
    assign w_irq_set   = |(w_flag_next & ~r_flag & w_en_bits);

    // Edge history, flags, enable and interrupt request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
            r_flag <= '0;
            r_en   <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= r_sync2;
            r_flag <= w_flag_next;
            if (write_strobe && port_id == 8'h30)
                r_en <= out_port[NUM_IN-1:0];
            r_irq <= w_irq_set | (r_irq & ~interrupt_ack);
        end
    end

    assign interrupt = r_irq;
`else
    assign interrupt = 1'b0;
`endif

    // Read decode; anything unmapped or unimplemented returns zero
    always_comb begin
        w_rd = 8'h00;
        case (port_id[7:4])
            4'h0: begin
                for (int i = 0; i < NUM_OUT; i++)
                    if (port_id[3:0] == 4'(i)) w_rd = r_out[i];
            end
            4'h1: begin
                for (int i = 0; i < NUM_IN; i++)
                    if (port_id[3:0] == 4'(i)) w_rd = r_sync2[8*i +: 8];
            end
`ifdef PIO_EDGE_IRQ_EN
            4'h2: begin
                for (int i = 0; i < NUM_IN; i++)
                    if (port_id[3:0] == 4'(i)) w_rd = r_flag[8*i +: 8];
            end
            4'h3: begin
                if (port_id[3:0] == 4'h0)
                    for (int i = 0; i < NUM_IN; i++) w_rd[i] = r_en[i];
            end
`endif
            default: w_rd = 8'h00;
        endcase
    end

    // Registered read data back to the processor
    always_ff @(posedge clk) begin
        if (reset) r_in_port <= 8'h00;
        else       r_in_port <= w_rd;
    end

    assign in_port = r_in_port;

endmodule

// File: tb/tb_pico_io_ports.sv
// Directed self-checking bench for pico_io_ports
// (covers both PIO_EDGE_IRQ_EN builds).
module tb_pico_io_ports;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_id;
    logic        write_strobe;
    logic        read_strobe;
    logic [7:0]  out_port;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        interrupt_ack;
    logic [15:0] in_pins;
    logic [15:0] out_pins;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pico_io_ports #(
        .NUM_OUT(2),
        .NUM_IN(2),
        .OUT_RESET(8'h81)
    ) dut (
        .clk(clk),
        .reset(reset),
        .port_id(port_id),
        .write_strobe(write_strobe),
        .read_strobe(read_strobe),
        .out_port(out_port),
        .in_port(in_port),
        .interrupt(interrupt),
        .interrupt_ack(interrupt_ack),
        .in_pins(in_pins),
        .out_pins(out_pins)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id      = a;
        out_port     = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input string tag);
        port_id     = a;
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        chk(tag, in_port, exp);
    endtask

    task automatic ack_pulse;
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        port_id       = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        out_port      = 8'h00;
        interrupt_ack = 1'b0;
        in_pins       = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_out0", out_pins[7:0], 8'h81);
        chk("rst_out1", out_pins[15:8], 8'h81);
        chk("rst_inport", in_port, 8'h00);
        chk("rst_irq", {7'b0, interrupt}, 8'h00);

        // Scenario 1: output register write and readback
        wr(8'h01, 8'hA5);
        chk("wr_out1", out_pins[15:8], 8'hA5);
        chk("wr_out0_keep", out_pins[7:0], 8'h81);
        rd(8'h01, 8'hA5, "rd_out1");
        rd(8'h00, 8'h81, "rd_out0");

        // Ignored writes: unimplemented index, input space, no strobe
        wr(8'h02, 8'hFF);
        wr(8'h10, 8'hFF);
        port_id  = 8'h00;
        out_port = 8'h77;
        tick();
        chk("ign_out", out_pins[7:0], 8'h81);
        chk("ign_out1", out_pins[15:8], 8'hA5);

        // Scenario 2: synchronized inputs, 2-flop + registered read
        in_pins = 16'h963C;
        rd(8'h10, 8'h00, "sync_e1");
        rd(8'h10, 8'h00, "sync_e2");
        rd(8'h10, 8'h3C, "sync_e3");
        rd(8'h11, 8'h96, "sync_in1");
        rd(8'h55, 8'h00, "unmapped");
        rd(8'h12, 8'h00, "unimpl_in");

`ifdef PIO_EDGE_IRQ_EN
        // Rising edges latched while disabled: no interrupt
        chk("dis_irq", {7'b0, interrupt}, 8'h00);
        rd(8'h20, 8'h3C, "flag0");
        rd(8'h21, 8'h96, "flag1");
        // Enabling with pending flags does not raise interrupt
        wr(8'h30, 8'h01);
        tick();
        tick();
        chk("en_pend_irq", {7'b0, interrupt}, 8'h00);
        rd(8'h30, 8'h01, "rd_en");
        rd(8'h20, 8'h3C, "flag_noclr");
        wr(8'h20, 8'hFF);
        wr(8'h21, 8'hFF);
        rd(8'h20, 8'h00, "flag_clr0");
        rd(8'h21, 8'h00, "flag_clr1");

        // Scenario 3: enabled edge -> flag + interrupt, ack, W1C
        in_pins[0] = 1'b1;
        tick();
        tick();
        chk("s3_irq_early", {7'b0, interrupt}, 8'h00);
        tick();
        chk("s3_irq", {7'b0, interrupt}, 8'h01);
        rd(8'h20, 8'h01, "s3_flag");
        ack_pulse();
        chk("s3_ack", {7'b0, interrupt}, 8'h00);
        rd(8'h20, 8'h01, "s3_flag_kept");
        wr(8'h20, 8'h01);
        rd(8'h20, 8'h00, "s3_w1c");

        // Falling edge ignored
        in_pins[0] = 1'b0;
        repeat (4) tick();
        rd(8'h20, 8'h00, "fall_flag");
        chk("fall_irq", {7'b0, interrupt}, 8'h00);

        // Scenario 4: W1C coincides with new rising edge -> set wins
        in_pins[0] = 1'b1;
        tick();
        tick();
        wr(8'h20, 8'h01);
        rd(8'h20, 8'h01, "s4_setwins");
        chk("s4_irq", {7'b0, interrupt}, 8'h01);

        // Scenario 5: ack coincides with new enabled edge -> stays 1
        wr(8'h20, 8'h01);
        ack_pulse();
        chk("s5_pre", {7'b0, interrupt}, 8'h00);
        in_pins[0] = 1'b0;
        repeat (4) tick();
        in_pins[0] = 1'b1;
        tick();
        tick();
        ack_pulse();
        chk("s5_irq", {7'b0, interrupt}, 8'h01);
        rd(8'h20, 8'h01, "s5_flag");

        // Scenario 6 setup: flags 0xFF on port 0, interrupt high
        wr(8'h00, 8'h5A);
        in_pins[7:0] = 8'h00;
        repeat (4) tick();
        wr(8'h20, 8'hFF);
        in_pins[7:0] = 8'hFF;
        repeat (3) tick();
        rd(8'h20, 8'hFF, "s6_flags");
        chk("s6_irq", {7'b0, interrupt}, 8'h01);
`else
        // Without the edge logic: 0x20-0x30 read zero, interrupt low
        rd(8'h20, 8'h00, "noirq_flag");
        wr(8'h30, 8'h03);
        rd(8'h30, 8'h00, "noirq_en");
        in_pins[0] = 1'b1;
        repeat (4) tick();
        ack_pulse();
        chk("noirq_irq", {7'b0, interrupt}, 8'h00);
        wr(8'h00, 8'h5A);
        wr(8'h20, 8'hFF);
        rd(8'h20, 8'h00, "noirq_flag2");
`endif

        // Scenario 6: reset mid-operation
        chk("s6_out0", out_pins[7:0], 8'h5A);
        port_id = 8'h00;
        tick();
        chk("s6_pre_inport", in_port, 8'h5A);
        reset = 1'b1;
        wr(8'h01, 8'h33);
        reset = 1'b0;
        chk("s6_rst_out0", out_pins[7:0], 8'h81);
        chk("s6_rst_out1", out_pins[15:8], 8'h81);
        chk("s6_rst_inport", in_port, 8'h00);
        chk("s6_rst_irq", {7'b0, interrupt}, 8'h00);
        rd(8'h20, 8'h00, "s6_rst_flag");
        rd(8'h30, 8'h00, "s6_rst_en");
`ifdef PIO_EDGE_IRQ_EN
        // Pin held high re-flags once after reset, enable is clear
        tick();
        tick();
        rd(8'h20, 8'hFF, "s6_reflag");
        chk("s6_reflag_irq", {7'b0, interrupt}, 8'h00);
`else
        repeat (3) tick();
        rd(8'h20, 8'h00, "s6_noflag");
        chk("s6_irq_off", {7'b0, interrupt}, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pico_io_ports.md
PICO_IO_PORTS -- requirements
Module: pico_io_ports

Interface
REQ-001 Parameter NUM_OUT, default 2: number of 8-bit output registers, legal range 1..16.
REQ-002 Parameter NUM_IN, default 2: number of 8-bit input ports, legal range 1..8.
REQ-003 Parameter OUT_RESET, default 8'h00: value loaded into every output register at reset.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 port_id  in  8  KCPSM3 port address.
REQ-007 write_strobe  in  1  KCPSM3 output strobe, one-cycle pulse qualifying out_port and port_id.
REQ-008 read_strobe  in  1  KCPSM3 input strobe; informational only, no side effects.
REQ-009 out_port  in  8  KCPSM3 write data.
REQ-010 in_port  out  8  registered read data to KCPSM3.
REQ-011 interrupt  out  1  registered interrupt request to KCPSM3.
REQ-012 interrupt_ack  in  1  KCPSM3 interrupt acknowledge pulse.
REQ-013 in_pins  in  8*NUM_IN  asynchronous external inputs, port i on bits [8i+7:8i].
REQ-014 out_pins  out  8*NUM_OUT  output register contents, port i on bits [8i+7:8i].

Function
REQ-015 Address map: 0x00+i output reg i (R/W); 0x10+i synchronized input i (R); 0x20+i edge flags i (R, write-1-to-clear); 0x30 interrupt enable, bit i enables input port i (R/W).
REQ-016 Write: when write_strobe=1 and port_id selects a writable location, that location takes out_port at the same clock edge; otherwise no state changes.
REQ-017 Writes to 0x10-0x1F, to unimplemented indices, or to any unmapped address are ignored.
REQ-018 out_pins reflect the output registers directly, with no added latency after the write edge.
REQ-019 Each in_pins bit passes through a 2-flop synchronizer; the 0x10+i read value is the second-stage value.
REQ-020 Read: in_port is registered every cycle from the port_id decode; data is valid one cycle after port_id is applied; unmapped or unimplemented addresses read 8'h00.
REQ-021 Reads have no side effects; flags are never cleared by a read.
REQ-022 Edge flag bit sets on the cycle after its synchronized input goes 0->1 (sync stage2=1, previous=0); falling edges are ignored.
REQ-023 Flag clear: writing 1 to a flag bit clears it; writing 0 leaves it unchanged.
REQ-024 If a set and a clear hit the same flag bit in the same cycle, the set wins.
REQ-025 interrupt sets at the edge after any flag bit goes 0->1 while its port's enable bit is 1.
REQ-026 interrupt clears at the edge after interrupt_ack=1.
REQ-027 If a new enabled flag set coincides with interrupt_ack, interrupt stays 1 so no event is lost.
REQ-028 Enabling a port that already has pending flags does not by itself assert interrupt.

Reset
REQ-029 On reset=1 at a clock edge, the following load: output regs to OUT_RESET, synchronizer and previous-value flops to 0, flags to 0, interrupt enable to 0x00, in_port to 0x00, interrupt to 0.
REQ-030 Reset has priority over any write, edge or ack in the same cycle.
REQ-031 After reset deasserts, edge detection restarts from a previous value of 0, so a pin held high yields one flag set once it has passed the synchronizer.

Configuration
REQ-032 With macro PIO_EDGE_IRQ_EN defined, the edge flags, the interrupt enable register and the interrupt logic are implemented as in REQ-022 to REQ-028.
REQ-033 Without PIO_EDGE_IRQ_EN, no flag or enable storage exists, 0x20-0x30 read 8'h00 and ignore writes, interrupt is constant 0, and interrupt_ack is ignored.

Verification
REQ-034 Scenario 1: after reset, write 0xA5 to 0x01 -> out_pins[15:8]=0xA5 the next cycle; read 0x01 gives in_port=0xA5 one cycle after port_id; out_pins[7:0]=OUT_RESET.
REQ-035 Scenario 2: in_pins[7:0]=0x3C -> read 0x10 returns 0x3C no earlier than the 2-cycle sync delay; read 0x55 returns 0x00.
REQ-036 Scenario 3 (macro on): enable=0x01, in_pins[0] 0->1 -> flag 0x20 reads 0x01 and interrupt=1; pulse interrupt_ack -> interrupt=0 and the flag is still 0x01; write 0x01 to 0x20 -> flag reads 0x00.
REQ-037 Scenario 4 (macro on): a W1C write of 0x01 to 0x20 in the same cycle as a new bit-0 rising edge -> flag reads 0x01.
REQ-038 Scenario 5 (macro on): a new enabled edge in the same cycle as interrupt_ack -> interrupt remains 1.
REQ-039 Scenario 6: assert reset mid-operation with out reg 0x5A, flags 0xFF and interrupt=1 -> next cycle all registers hold their reset values and interrupt=0; with the macro off, interrupt=0 and 0x20 reads 0x00 throughout.
